// File: rtl/iter_div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Widths here describe the standard 32-bit configuration.
package iter_div_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_CNT_W = 6;

    // Field order makes bit [0] the div flag, matching the one-hot op encoding.
    typedef struct packed {
        logic remu;
        logic rem;
        logic divu;
        logic div;
    } div_op_type;

    typedef struct packed {
        logic [DIV_XLEN-1:0] rdata1;
        logic [DIV_XLEN-1:0] rdata2;
        logic                enable;
        div_op_type          div_op;
    } div_in_type;

    typedef struct packed {
        logic [DIV_XLEN-1:0] result;
        logic                ready;
    } div_out_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        div_state_e           state;
        logic [DIV_XLEN-1:0]  q;
        logic [DIV_XLEN-1:0]  r;
        logic [DIV_XLEN-1:0]  d;
        logic [DIV_CNT_W-1:0] cnt;
        logic                 neg_q;
        logic                 neg_r;
        logic                 is_rem;
        logic [DIV_XLEN-1:0]  result;
        logic                 ready;
    } div_reg_type;

    localparam div_reg_type init_div_reg = '{
        state:  IDLE,
        q:      '0,
        r:      '0,
        d:      '0,
        cnt:    '0,
        neg_q:  1'b0,
        neg_r:  1'b0,
        is_rem: 1'b0,
        result: '0,
        ready:  1'b0
    };

endpackage

// File: rtl/iter_div_if.sv
// Execute-stage division handshake: operands and start pulse in, result and ready out.
interface iter_div_if #(
    parameter int XLEN = 32
);
    logic            div_in_enable;
    logic [XLEN-1:0] div_in_rdata1;
    logic [XLEN-1:0] div_in_rdata2;
    logic [3:0]      div_in_div_op;
    logic [XLEN-1:0] div_out_result;
    logic            div_out_ready;

    modport master (
        output div_in_enable,
        output div_in_rdata1,
        output div_in_rdata2,
        output div_in_div_op,
        input  div_out_result,
        input  div_out_ready
    );

    modport slave (
        input  div_in_enable,
        input  div_in_rdata1,
        input  div_in_rdata2,
        input  div_in_div_op,
        output div_out_result,
        output div_out_ready
    );
endinterface

// File: rtl/iter_div_step.sv
// One radix-2 restoring iteration: shift {R,Q} left, trial-subtract D, keep or restore.
module iter_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] r_i,
    input  logic [XLEN-1:0] q_i,
    input  logic [XLEN-1:0] d_i,
    output logic [XLEN-1:0] r_o,
    output logic [XLEN-1:0] q_o
);
    logic [XLEN-1:0] rs_lo;
    logic [XLEN-1:0] diff;
    logic            borrow;
    logic            ge;

    // The bit shifted out of R is the 2^XLEN weight of the trial; if set, R_shifted > D always.
    always_comb begin
        rs_lo          = {r_i[XLEN-2:0], q_i[XLEN-1]};
        {borrow, diff} = {1'b0, rs_lo} - {1'b0, d_i};
        ge             = r_i[XLEN-1] | ~borrow;
        r_o            = ge ? diff : rs_lo;
        q_o            = {q_i[XLEN-2:0], ge};
    end
endmodule

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Special cases finish in one cycle; the normal path takes XLEN iterations.
module iter_div
    import iter_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic      clock,
    input  logic      reset,
    iter_div_if.slave bus
);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_op_type      op;
    logic            op_valid;
    logic            is_signed;
    logic            is_rem;
    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            ovf;

    div_state_e       state_q;
    logic [XLEN-1:0]  q_q;
    logic [XLEN-1:0]  r_q;
    logic [XLEN-1:0]  d_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             is_rem_q;
    logic [XLEN-1:0]  result_q;
    logic             ready_q;

    logic [XLEN-1:0]  q_d;
    logic [XLEN-1:0]  r_d;

    // Priority decode: div > divu > rem > remu.
    always_comb begin
        op        = div_op_type'(bus.div_in_div_op);
        op_valid  = op.div | op.divu | op.rem | op.remu;
        is_signed = op.div | (~op.divu & op.rem);
        is_rem    = ~op.div & ~op.divu & (op.rem | op.remu);
        sign1     = is_signed & bus.div_in_rdata1[XLEN-1];
        sign2     = is_signed & bus.div_in_rdata2[XLEN-1];
        mag1      = sign1 ? (~bus.div_in_rdata1 + 1'b1) : bus.div_in_rdata1;
        mag2      = sign2 ? (~bus.div_in_rdata2 + 1'b1) : bus.div_in_rdata2;
        div_zero  = (bus.div_in_rdata2 == '0);
        ovf       = is_signed & (bus.div_in_rdata1 == INT_MIN) & (bus.div_in_rdata2 == '1);
    end

    iter_div_step #(
        .XLEN(XLEN)
    ) u_step (
        .r_i(r_q),
        .q_i(q_q),
        .d_i(d_q),
        .r_o(r_d),
        .q_o(q_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            q_q      <= '0;
            r_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            is_rem_q <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else if (bus.div_in_enable && op_valid) begin
            // A new request always wins, discarding any operation in flight.
            if (div_zero) begin
                state_q  <= DONE;
                ready_q  <= 1'b1;
                result_q <= is_rem ? bus.div_in_rdata1 : '1;
            end else if (ovf) begin
                state_q  <= DONE;
                ready_q  <= 1'b1;
                result_q <= is_rem ? '0 : INT_MIN;
            end else begin
                state_q  <= BUSY;
                ready_q  <= 1'b0;
                q_q      <= mag1;
                r_q      <= '0;
                d_q      <= mag2;
                cnt_q    <= CNT_W'(XLEN - 1);
                neg_q_q  <= sign1 ^ sign2;
                neg_r_q  <= sign1;
                is_rem_q <= is_rem;
            end
        end else begin
            case (state_q)
                BUSY: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        if (is_rem_q) result_q <= neg_r_q ? (~r_d + 1'b1) : r_d;
                        else          result_q <= neg_q_q ? (~q_d + 1'b1) : q_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.div_out_result = result_q;
    assign bus.div_out_ready  = ready_q;
endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div: arithmetic, special cases, latency, restart and reset.
module tb_iter_div;
    localparam logic [3:0] OP_DIV  = 4'b0001;
    localparam logic [3:0] OP_DIVU = 4'b0010;
    localparam logic [3:0] OP_REM  = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b1000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    iter_div_if #(.XLEN(32)) bus ();

    iter_div #(.XLEN(32), .CNT_W(6)) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start one operation and measure cycles until ready (1 = cycle after enable).
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic after);
        @(negedge clk);
        bus.div_in_enable = 1'b1;
        bus.div_in_div_op = op;
        bus.div_in_rdata1 = a;
        bus.div_in_rdata2 = b;
        @(negedge clk);
        bus.div_in_enable = 1'b0;
        lat = 1;
        while (bus.div_out_ready !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = bus.div_out_result;
        @(negedge clk);
        after = bus.div_out_ready;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.div_out_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b want 0", bus.div_out_ready);
        end
        checks++;
        if (bus.div_out_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result got %h want 00000000", bus.div_out_result);
        end
    endtask

    task automatic test_unsigned();
        int lat; logic [31:0] res; logic after;
        run(OP_DIVU, 32'd100, 32'd7, lat, res, after);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", lat); end
        checks++;
        if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h want %h", res, 32'd14); end
        checks++;
        if (after !== 1'b0) begin errors++; $display("FAIL ready_pulse_width got %b want 0", after); end
        run(OP_REMU, 32'd100, 32'd7, lat, res, after);
        checks++;
        if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h want %h", res, 32'd2); end
        run(OP_DIVU, 32'hFFFF_FFFF, 32'd1, lat, res, after);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_max_1 got %h want ffffffff", res); end
        run(OP_REMU, 32'hFFFF_FFFF, 32'h10, lat, res, after);
        checks++;
        if (res !== 32'hF) begin errors++; $display("FAIL remu_max_16 got %h want 0000000f", res); end
        run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, after);
        checks++;
        if (res !== 32'h0) begin errors++; $display("FAIL divu_min_allones got %h want 00000000", res); end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL divu_no_ovf_latency got %0d want 33", lat); end
    endtask

    task automatic test_signed();
        int lat; logic [31:0] res; logic after;
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, res, after);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got %h want fffffffd", res); end
        run(OP_REM, 32'hFFFF_FFF9, 32'd2, lat, res, after);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 got %h want ffffffff", res); end
        run(OP_REM, 32'd7, 32'hFFFF_FFFE, lat, res, after);
        checks++;
        if (res !== 32'd1) begin errors++; $display("FAIL rem_7_m2 got %h want 00000001", res); end
        run(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, res, after);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2 got %h want fffffffd", res); end
        // All op bits set: div has priority.
        run(4'b1111, 32'hFFFF_FFF9, 32'd2, lat, res, after);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL op_priority got %h want fffffffd", res); end
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] res; logic after;
        run(OP_DIV, 32'd5, 32'd0, lat, res, after);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL divzero_latency got %0d want 1", lat); end
        checks++;
        if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_5_0 got %h want ffffffff", res); end
        checks++;
        if (after !== 1'b0) begin errors++; $display("FAIL divzero_pulse_width got %b want 0", after); end
        run(OP_REM, 32'd5, 32'd0, lat, res, after);
        checks++;
        if (res !== 32'd5) begin errors++; $display("FAIL rem_5_0 got %h want 00000005", res); end
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] res; logic after;
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, after);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL ovf_latency got %0d want 1", lat); end
        checks++;
        if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got %h want 80000000", res); end
        run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, after);
        checks++;
        if (res !== 32'h0) begin errors++; $display("FAIL rem_ovf got %h want 00000000", res); end
    endtask

    task automatic test_abort();
        int pulses; int first; logic [31:0] res;
        @(negedge clk);
        bus.div_in_enable = 1'b1;
        bus.div_in_div_op = OP_DIVU;
        bus.div_in_rdata1 = 32'd1000;
        bus.div_in_rdata2 = 32'd3;
        @(negedge clk);
        bus.div_in_enable = 1'b0;
        pulses = 0; first = 0; res = '0;
        for (int c = 1; c < 10; c++) begin
            if (bus.div_out_ready === 1'b1) pulses++;
            @(negedge clk);
        end
        // Now at cycle 10: restart with new operands.
        bus.div_in_enable = 1'b1;
        bus.div_in_rdata1 = 32'd9;
        bus.div_in_rdata2 = 32'd3;
        @(negedge clk);
        bus.div_in_enable = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (bus.div_out_ready === 1'b1) begin
                pulses++;
                if (first == 0) begin first = c; res = bus.div_out_result; end
            end
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL abort_pulses got %0d want 1", pulses); end
        checks++;
        if (first !== 33) begin errors++; $display("FAIL abort_latency got %0d want 33", first); end
        checks++;
        if (res !== 32'd3) begin errors++; $display("FAIL abort_result got %h want 00000003", res); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res;
        @(negedge clk);
        bus.div_in_enable = 1'b1;
        bus.div_in_div_op = OP_DIVU;
        bus.div_in_rdata1 = 32'd5;
        bus.div_in_rdata2 = 32'd0;
        @(negedge clk);
        checks++;
        if (bus.div_out_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got %b want 1", bus.div_out_ready); end
        // Enable during the DONE cycle restarts immediately.
        bus.div_in_rdata1 = 32'd100;
        bus.div_in_rdata2 = 32'd7;
        @(negedge clk);
        bus.div_in_enable = 1'b0;
        lat = 1;
        while (bus.div_out_ready !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = bus.div_out_result;
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
        checks++;
        if (res !== 32'd14) begin errors++; $display("FAIL b2b_result got %h want 0000000e", res); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        bus.div_in_enable = 1'b1;
        bus.div_in_div_op = OP_DIVU;
        bus.div_in_rdata1 = 32'd1000;
        bus.div_in_rdata2 = 32'd3;
        @(negedge clk);
        bus.div_in_enable = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.div_out_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %b want 0", bus.div_out_ready); end
        checks++;
        if (bus.div_out_result !== 32'h0) begin errors++; $display("FAIL midreset_result got %h want 00000000", bus.div_out_result); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.div_out_ready === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL midreset_pulses got %0d want 0", pulses); end
    endtask

    task automatic test_op_zero();
        int pulses;
        @(negedge clk);
        bus.div_in_enable = 1'b1;
        bus.div_in_div_op = 4'b0000;
        bus.div_in_rdata1 = 32'd5;
        bus.div_in_rdata2 = 32'd0;
        @(negedge clk);
        bus.div_in_enable = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.div_out_ready === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL opzero_pulses got %0d want 0", pulses); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.div_in_enable = 1'b0;
        bus.div_in_div_op = 4'b0000;
        bus.div_in_rdata1 = '0;
        bus.div_in_rdata2 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_op_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/iter_div.md
Name: iter_div

Overview:
- Iterative radix-2 restoring divider that answers the execute stage's division handshake for RV32M DIV/DIVU/REM/REMU.
- Sits beside the execute stage. Execute pulses enable with operands; the divider returns the result with a one-cycle ready.
- While ready is low, the execute stage holds the instruction (stall).

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (>= clog2(XLEN)+1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (reset==0 resets)
div_in_enable  in  1  start pulse; operands and op sampled when high
div_in_rdata1  in  XLEN  dividend (rs1)
div_in_rdata2  in  XLEN  divisor (rs2)
div_in_div_op  in  4  one-hot op: [0]=div [1]=divu [2]=rem [3]=remu
div_out_result  out  XLEN  quotient or remainder; valid when ready=1
div_out_ready  out  1  one-cycle pulse, result valid

Behaviour:
- Reset (asynchronous, any state): state=IDLE, ready=0, result=0, counter=0, internal regs=0. Reset mid-operation discards the operation, and no ready is produced.
- States: IDLE, BUSY, DONE.
- Op decode, by priority: div > divu > rem > remu. If enable=1 with op==0, the request is ignored and state is unchanged.
- Start: enable=1 in any state (including BUSY or DONE) aborts current work and restarts with the new operands. The old result is never signalled.
- Signed ops (div, rem): take magnitudes of the operands; record neg_q = sign1^sign2 and neg_r = sign1.
- Special cases are detected at start, bypass BUSY and go straight to DONE. Ready rises the cycle after enable (latency 1).
  - Divisor==0: quotient = all ones; remainder = rdata1.
  - Signed overflow (rdata1 = 0x8000_0000, rdata2 = 0xFFFF_FFFF): quotient = 0x8000_0000; remainder = 0.
- Normal path:
  - At start: load Q=|dividend|, R=0, D=|divisor|, counter=XLEN-1, then go to BUSY.
  - Each BUSY cycle: {R,Q} shifted left 1; trial = R_shifted - D, computed XLEN+1 bits wide.
    - If trial is non-negative: R=trial and Q[0]=1.
    - Otherwise R=R_shifted and Q[0]=0.
  - Counter decrements each cycle. When counter==0 the iteration completes and state goes to DONE.
- On the transition into DONE, the result register is loaded:
  - Quotient ops: negated if neg_q.
  - Remainder ops: negated if neg_r.
- Normal latency: enable in cycle 0, BUSY in cycles 1..XLEN, ready=1 in cycle XLEN+1 (33 for XLEN=32).
- DONE lasts exactly one cycle (ready=1), then IDLE with ready=0. Enable in the DONE cycle restarts, per the start rule.
- result is registered and holds its last value until the next DONE. ready and result are both registered outputs, with no combinational path from inputs.
- Enable while IDLE with a valid op always starts. There is no back-pressure; the requester consumes ready in the cycle it is high.

Decomposition:
- Shared package (constants/wires):
  - div_op_type as a 4-field packed struct (div, divu, rem, remu).
  - div_in_type {rdata1, rdata2, enable, div_op} and div_out_type {result, ready}; the top can wrap the flattened ports into these.
  - Divider state enum.
  - init_div_reg constant.
- Sub-module: div_step, a combinational single-iteration shift/subtract producing the next {R,Q}. It keeps the state machine readable and lets radix be raised later.

Test Plan:
- divu 100/7: enable one cycle, op=divu -> ready at cycle 33, result=14; remu same operands -> result=2.
- div -7/2 (0xFFFF_FFF9, 2) -> result 0xFFFF_FFFD (-3); rem -> 0xFFFF_FFFF (-1); rem 7/-2 -> 1.
- Divide by zero: div 5/0 -> ready at cycle 1, result 0xFFFF_FFFF; rem 5/0 -> result 5.
- Overflow: div 0x8000_0000 / 0xFFFF_FFFF -> ready at cycle 1, result 0x8000_0000; rem -> 0.
- Abort/restart: start divu 1000/3, re-enable at cycle 10 with divu 9/3 -> exactly one ready pulse, at cycle 10+33, result=3.
- Reset at cycle 15 of an operation -> ready=0 and result=0 immediately; no ready pulse afterward. Enable with op=0 -> no ready ever.
